tl_host_arbiter: RTL and testbench

Two-host TileLink-UL arbiter that shares one downstream TL port (A/D channels) between two requesters, e.g. the `axi_adapter_tl` bridge output and a second DMA/debug host, in front of the cache. Arbitrates A-channel messages with round-robin priority and holds the grant for every beat of a multi-beat write. It extends the A source ID by one bit to tag the requester, and routes D-channel beats back to the owning host by that bit.

---
 rtl/tl_host_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tl_host_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tl_host_arbiter
//  Purpose  : Two-host TileLink-UL arbiter sharing one downstream A/D port.
//             A-channel messages are granted round-robin and the grant is
//             held for every beat of a multi-beat Put.  The downstream source
//             ID is {host index, host source}.  D beats are routed back by
//             the top source bit.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    TL_HOST_ARB_FIXED_PRIO_EN  - host0 always wins in IDLE.  No priority
//                                 register is built.  Burst locking is kept.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rstn          clock and synchronous active-low reset
//    h0_a_*, h1_a_*     host A channels (valid/fields in, ready out)
//    h0_d_*, h1_d_*     host D channels (valid/fields out, ready in)
//    dev_a_*            downstream A channel (source one bit wider)
//    dev_d_*            downstream D channel (source one bit wider)
//  While rstn=0 every valid/ready output and every dev_a_* field is 0.
// ============================================================================
module tl_host_arbiter #(
    parameter int SourceWidth = 1,
    parameter int AddrWidth   = 56,
    parameter int DataWidth   = 64,
    parameter int SizeWidth   = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    // host 0 A
    input  logic                     h0_a_valid,
    output logic                     h0_a_ready,
    input  logic [2:0]               h0_a_opcode,
    input  logic [2:0]               h0_a_param,
    input  logic [SizeWidth-1:0]     h0_a_size,
    input  logic [SourceWidth-1:0]   h0_a_source,
    input  logic [AddrWidth-1:0]     h0_a_address,
    input  logic [DataWidth/8-1:0]   h0_a_mask,
    input  logic [DataWidth-1:0]     h0_a_data,
    input  logic                     h0_a_corrupt,
    // host 0 D
    output logic                     h0_d_valid,
    input  logic                     h0_d_ready,
    output logic [2:0]               h0_d_opcode,
    output logic [1:0]               h0_d_param,
    output logic [SizeWidth-1:0]     h0_d_size,
    output logic [SourceWidth-1:0]   h0_d_source,
    output logic                     h0_d_sink,
    output logic                     h0_d_denied,
    output logic                     h0_d_corrupt,
    output logic [DataWidth-1:0]     h0_d_data,
    // host 1 A
    input  logic                     h1_a_valid,
    output logic                     h1_a_ready,
    input  logic [2:0]               h1_a_opcode,
    input  logic [2:0]               h1_a_param,
    input  logic [SizeWidth-1:0]     h1_a_size,
    input  logic [SourceWidth-1:0]   h1_a_source,
    input  logic [AddrWidth-1:0]     h1_a_address,
    input  logic [DataWidth/8-1:0]   h1_a_mask,
    input  logic [DataWidth-1:0]     h1_a_data,
    input  logic                     h1_a_corrupt,
    // host 1 D
    output logic                     h1_d_valid,
    input  logic                     h1_d_ready,
    output logic [2:0]               h1_d_opcode,
    output logic [1:0]               h1_d_param,
    output logic [SizeWidth-1:0]     h1_d_size,
    output logic [SourceWidth-1:0]   h1_d_source,
    output logic                     h1_d_sink,
    output logic                     h1_d_denied,
    output logic                     h1_d_corrupt,
    output logic [DataWidth-1:0]     h1_d_data,
    // downstream A
    output logic                     dev_a_valid,
    input  logic                     dev_a_ready,
    output logic [2:0]               dev_a_opcode,
    output logic [2:0]               dev_a_param,
    output logic [SizeWidth-1:0]     dev_a_size,
    output logic [SourceWidth:0]     dev_a_source,
    output logic [AddrWidth-1:0]     dev_a_address,
    output logic [DataWidth/8-1:0]   dev_a_mask,
    output logic [DataWidth-1:0]     dev_a_data,
    output logic                     dev_a_corrupt,
    // downstream D
    input  logic                     dev_d_valid,
    output logic                     dev_d_ready,
    input  logic [2:0]               dev_d_opcode,
    input  logic [1:0]               dev_d_param,
    input  logic [SizeWidth-1:0]     dev_d_size,
    input  logic [SourceWidth:0]     dev_d_source,
    input  logic                     dev_d_sink,
    input  logic                     dev_d_denied,
    input  logic                     dev_d_corrupt,
    input  logic [DataWidth-1:0]     dev_d_data
);

    localparam int CW    = SizeWidth + 1;
    localparam int LOG2B = $clog2(DataWidth / 8);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_grant;
    logic [CW-1:0]   r_cnt;
    logic            w_prio;

    logic            w_grant;
    logic            w_a_valid;
    logic [2:0]      w_a_opcode;
    logic [2:0]      w_a_param;
    logic [SizeWidth-1:0]   w_a_size;
    logic [SourceWidth-1:0] w_a_source;
    logic [AddrWidth-1:0]   w_a_address;
    logic [DataWidth/8-1:0] w_a_mask;
    logic [DataWidth-1:0]   w_a_data;
    logic            w_a_corrupt;

    logic            w_accept;
    logic            w_multi;
    logic [SizeWidth-1:0] w_shamt;
    logic [CW-1:0]   w_beats_m1;
    logic            w_last;
    logic            w_dsel;

`ifdef TL_HOST_ARB_FIXED_PRIO_EN
    assign w_prio = 1'b0;
`else
    logic r_prio;
    assign w_prio = r_prio;
`endif

    // Grant: live arbitration in IDLE, frozen to the burst owner in LOCKED.
    always_comb begin
        w_grant = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_grant = r_grant;
        end else if (h0_a_valid && h1_a_valid) begin
            w_grant = w_prio;
        end else if (h1_a_valid) begin
            w_grant = 1'b1;
        end
    end

    always_comb begin
        w_a_valid   = h0_a_valid;
        w_a_opcode  = h0_a_opcode;
        w_a_param   = h0_a_param;
        w_a_size    = h0_a_size;
        w_a_source  = h0_a_source;
        w_a_address = h0_a_address;
        w_a_mask    = h0_a_mask;
        w_a_data    = h0_a_data;
        w_a_corrupt = h0_a_corrupt;
        if (w_grant) begin
            w_a_valid   = h1_a_valid;
            w_a_opcode  = h1_a_opcode;
            w_a_param   = h1_a_param;
            w_a_size    = h1_a_size;
            w_a_source  = h1_a_source;
            w_a_address = h1_a_address;
            w_a_mask    = h1_a_mask;
            w_a_data    = h1_a_data;
            w_a_corrupt = h1_a_corrupt;
        end
    end

    assign w_accept = rstn && w_a_valid && dev_a_ready;

    // Only Put messages larger than one beat are multi-beat.
    assign w_multi = (w_a_opcode <= 3'd1) && (w_a_size > SizeWidth'(LOG2B));
    assign w_shamt = w_a_size - SizeWidth'(LOG2B);
    // beats-1 computed modulo 2^CW: the largest burst (2^CW beats) wraps the
    // shift to zero, and the subtraction then yields the correct all-ones.
    assign w_beats_m1 = (CW'(1) << w_shamt) - CW'(1);

    assign w_last = w_accept &&
                    ((r_state == ST_LOCKED) ? (r_cnt == CW'(1)) : !w_multi);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_multi) begin
                        r_state <= ST_LOCKED;
                        r_grant <= w_grant;
                        r_cnt   <= w_beats_m1;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef TL_HOST_ARB_FIXED_PRIO_EN
    // Round-robin: the host that just completed a message yields priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_prio <= 1'b0;
        end else if (w_last) begin
            r_prio <= ~w_grant;
        end
    end
`endif

    // Downstream A outputs, held at zero during reset.
    assign dev_a_valid   = rstn && w_a_valid;
    assign dev_a_opcode  = rstn ? w_a_opcode  : '0;
    assign dev_a_param   = rstn ? w_a_param   : '0;
    assign dev_a_size    = rstn ? w_a_size    : '0;
    assign dev_a_source  = rstn ? {w_grant, w_a_source} : '0;
    assign dev_a_address = rstn ? w_a_address : '0;
    assign dev_a_mask    = rstn ? w_a_mask    : '0;
    assign dev_a_data    = rstn ? w_a_data    : '0;
    assign dev_a_corrupt = rstn && w_a_corrupt;

    assign h0_a_ready = rstn && dev_a_ready && !w_grant;
    assign h1_a_ready = rstn && dev_a_ready &&  w_grant;

    // D path: stateless steering by the requester tag bit.
    assign w_dsel      = dev_d_source[SourceWidth];
    assign h0_d_valid  = rstn && dev_d_valid && !w_dsel;
    assign h1_d_valid  = rstn && dev_d_valid &&  w_dsel;
    assign dev_d_ready = rstn && (w_dsel ? h1_d_ready : h0_d_ready);

    assign h0_d_opcode  = dev_d_opcode;
    assign h0_d_param   = dev_d_param;
    assign h0_d_size    = dev_d_size;
    assign h0_d_source  = dev_d_source[SourceWidth-1:0];
    assign h0_d_sink    = dev_d_sink;
    assign h0_d_denied  = dev_d_denied;
    assign h0_d_corrupt = dev_d_corrupt;
    assign h0_d_data    = dev_d_data;

    assign h1_d_opcode  = dev_d_opcode;
    assign h1_d_param   = dev_d_param;
    assign h1_d_size    = dev_d_size;
    assign h1_d_source  = dev_d_source[SourceWidth-1:0];
    assign h1_d_sink    = dev_d_sink;
    assign h1_d_denied  = dev_d_denied;
    assign h1_d_corrupt = dev_d_corrupt;
    assign h1_d_data    = dev_d_data;

endmodule
`default_nettype wire

// File: tb/tb_tl_host_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_host_arbiter
//  Purpose  : Randomized self-checking bench for tl_host_arbiter against a
//             message-level reference model (owner / beats left / priority).
//  Revision : 1.0  - initial release
// ============================================================================
module tb_tl_host_arbiter;

    logic        clk = 1'b0;
    logic        rstn;

    logic        h0_a_valid, h0_a_ready, h1_a_valid, h1_a_ready;
    logic [2:0]  h0_a_opcode, h0_a_param, h1_a_opcode, h1_a_param;
    logic [2:0]  h0_a_size, h1_a_size;
    logic [0:0]  h0_a_source, h1_a_source;
    logic [55:0] h0_a_address, h1_a_address;
    logic [7:0]  h0_a_mask, h1_a_mask;
    logic [63:0] h0_a_data, h1_a_data;
    logic        h0_a_corrupt, h1_a_corrupt;

    logic        h0_d_valid, h0_d_ready, h1_d_valid, h1_d_ready;
    logic [2:0]  h0_d_opcode, h1_d_opcode;
    logic [1:0]  h0_d_param, h1_d_param;
    logic [2:0]  h0_d_size, h1_d_size;
    logic [0:0]  h0_d_source, h1_d_source;
    logic        h0_d_sink, h1_d_sink, h0_d_denied, h1_d_denied;
    logic        h0_d_corrupt, h1_d_corrupt;
    logic [63:0] h0_d_data, h1_d_data;

    logic        dev_a_valid, dev_a_ready;
    logic [2:0]  dev_a_opcode, dev_a_param, dev_a_size;
    logic [1:0]  dev_a_source;
    logic [55:0] dev_a_address;
    logic [7:0]  dev_a_mask;
    logic [63:0] dev_a_data;
    logic        dev_a_corrupt;

    logic        dev_d_valid, dev_d_ready;
    logic [2:0]  dev_d_opcode, dev_d_size;
    logic [1:0]  dev_d_param;
    logic [1:0]  dev_d_source;
    logic        dev_d_sink, dev_d_denied, dev_d_corrupt;
    logic [63:0] dev_d_data;

    tl_host_arbiter u_dut (
        .clk(clk), .rstn(rstn),
        .h0_a_valid(h0_a_valid), .h0_a_ready(h0_a_ready), .h0_a_opcode(h0_a_opcode),
        .h0_a_param(h0_a_param), .h0_a_size(h0_a_size), .h0_a_source(h0_a_source),
        .h0_a_address(h0_a_address), .h0_a_mask(h0_a_mask), .h0_a_data(h0_a_data),
        .h0_a_corrupt(h0_a_corrupt),
        .h0_d_valid(h0_d_valid), .h0_d_ready(h0_d_ready), .h0_d_opcode(h0_d_opcode),
        .h0_d_param(h0_d_param), .h0_d_size(h0_d_size), .h0_d_source(h0_d_source),
        .h0_d_sink(h0_d_sink), .h0_d_denied(h0_d_denied), .h0_d_corrupt(h0_d_corrupt),
        .h0_d_data(h0_d_data),
        .h1_a_valid(h1_a_valid), .h1_a_ready(h1_a_ready), .h1_a_opcode(h1_a_opcode),
        .h1_a_param(h1_a_param), .h1_a_size(h1_a_size), .h1_a_source(h1_a_source),
        .h1_a_address(h1_a_address), .h1_a_mask(h1_a_mask), .h1_a_data(h1_a_data),
        .h1_a_corrupt(h1_a_corrupt),
        .h1_d_valid(h1_d_valid), .h1_d_ready(h1_d_ready), .h1_d_opcode(h1_d_opcode),
        .h1_d_param(h1_d_param), .h1_d_size(h1_d_size), .h1_d_source(h1_d_source),
        .h1_d_sink(h1_d_sink), .h1_d_denied(h1_d_denied), .h1_d_corrupt(h1_d_corrupt),
        .h1_d_data(h1_d_data),
        .dev_a_valid(dev_a_valid), .dev_a_ready(dev_a_ready), .dev_a_opcode(dev_a_opcode),
        .dev_a_param(dev_a_param), .dev_a_size(dev_a_size), .dev_a_source(dev_a_source),
        .dev_a_address(dev_a_address), .dev_a_mask(dev_a_mask), .dev_a_data(dev_a_data),
        .dev_a_corrupt(dev_a_corrupt),
        .dev_d_valid(dev_d_valid), .dev_d_ready(dev_d_ready), .dev_d_opcode(dev_d_opcode),
        .dev_d_param(dev_d_param), .dev_d_size(dev_d_size), .dev_d_source(dev_d_source),
        .dev_d_sink(dev_d_sink), .dev_d_denied(dev_d_denied), .dev_d_corrupt(dev_d_corrupt),
        .dev_d_data(dev_d_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: which host owns an unfinished burst, how many beats
    // of it remain, and which host has priority for the next contest.
    int m_owner = 0;
    int m_left  = 0;
    int m_prio  = 0;

    function automatic int beats_of(input logic [2:0] op, input logic [2:0] sz);
        int bytes = 1 << sz;
        if ((op == 3'd0 || op == 3'd1) && bytes > 8) return bytes / 8;
        return 1;
    endfunction

    function automatic logic [2:0] pick_op();
        case ($urandom_range(0, 2))
            0:       return 3'd0;
            1:       return 3'd1;
            default: return 3'd4;
        endcase
    endfunction

    task automatic drive_random();
        rstn          = (cyc < 4) ? 1'b0 : ($urandom_range(0, 99) >= 2);
        h0_a_valid    = ($urandom_range(0, 9) < 7);
        h1_a_valid    = ($urandom_range(0, 9) < 7);
        h0_a_opcode   = pick_op();
        h1_a_opcode   = pick_op();
        h0_a_param    = 3'($urandom());
        h1_a_param    = 3'($urandom());
        h0_a_size     = 3'($urandom_range(0, 7));
        h1_a_size     = 3'($urandom_range(0, 7));
        h0_a_source   = 1'($urandom());
        h1_a_source   = 1'($urandom());
        h0_a_address  = 56'({$urandom(), $urandom()});
        h1_a_address  = 56'({$urandom(), $urandom()});
        h0_a_mask     = 8'($urandom());
        h1_a_mask     = 8'($urandom());
        h0_a_data     = {$urandom(), $urandom()};
        h1_a_data     = {$urandom(), $urandom()};
        h0_a_corrupt  = 1'($urandom());
        h1_a_corrupt  = 1'($urandom());
        dev_a_ready   = ($urandom_range(0, 3) != 0);
        h0_d_ready    = 1'($urandom());
        h1_d_ready    = 1'($urandom());
        dev_d_valid   = 1'($urandom());
        dev_d_opcode  = 3'($urandom());
        dev_d_param   = 2'($urandom());
        dev_d_size    = 3'($urandom());
        dev_d_source  = 2'($urandom());
        dev_d_sink    = 1'($urandom());
        dev_d_denied  = 1'($urandom());
        dev_d_corrupt = 1'($urandom());
        dev_d_data    = {$urandom(), $urandom()};
    endtask

    task automatic check_and_step();
        int g;
        logic ev;
        logic [55:0] eaddr;
        logic [63:0] edata;
        logic [2:0]  eop, esz;
        logic        esrc;
        int sel;
        if (!rstn) begin
            check("rst_dev_a_valid", 64'(dev_a_valid), 64'd0);
            check("rst_h0_a_ready",  64'(h0_a_ready),  64'd0);
            check("rst_h1_a_ready",  64'(h1_a_ready),  64'd0);
            check("rst_dev_a_addr",  64'(dev_a_address), 64'd0);
            check("rst_dev_a_src",   64'(dev_a_source), 64'd0);
            check("rst_h0_d_valid",  64'(h0_d_valid),  64'd0);
            check("rst_h1_d_valid",  64'(h1_d_valid),  64'd0);
            check("rst_dev_d_ready", 64'(dev_d_ready), 64'd0);
            m_owner = 0;
            m_left  = 0;
            m_prio  = 0;
            return;
        end
        // A-channel expectation
        if (m_left > 0)                    g = m_owner;
        else if (h0_a_valid && h1_a_valid) g = m_prio;
        else if (h1_a_valid)               g = 1;
        else                               g = 0;
        ev    = (g == 1) ? h1_a_valid   : h0_a_valid;
        eaddr = (g == 1) ? h1_a_address : h0_a_address;
        edata = (g == 1) ? h1_a_data    : h0_a_data;
        eop   = (g == 1) ? h1_a_opcode  : h0_a_opcode;
        esz   = (g == 1) ? h1_a_size    : h0_a_size;
        esrc  = (g == 1) ? h1_a_source[0] : h0_a_source[0];
        check("dev_a_valid", 64'(dev_a_valid), 64'(ev));
        check("h0_a_ready",  64'(h0_a_ready),  64'(dev_a_ready && g == 0));
        check("h1_a_ready",  64'(h1_a_ready),  64'(dev_a_ready && g == 1));
        if (ev) begin
            check("dev_a_source", 64'(dev_a_source), 64'(g * 2 + int'(esrc)));
            check("dev_a_addr",   64'(dev_a_address), 64'(eaddr));
            check("dev_a_data",   dev_a_data, edata);
            check("dev_a_opsize", 64'({dev_a_opcode, dev_a_size}), 64'({eop, esz}));
        end
        // D-channel expectation
        sel = int'(dev_d_source[1]);
        check("h0_d_valid",  64'(h0_d_valid),  64'(dev_d_valid && sel == 0));
        check("h1_d_valid",  64'(h1_d_valid),  64'(dev_d_valid && sel == 1));
        check("dev_d_ready", 64'(dev_d_ready), 64'((sel == 1) ? h1_d_ready : h0_d_ready));
        check("h_d_source",  64'({h0_d_source, h1_d_source}), 64'({2{dev_d_source[0]}}));
        check("h1_d_data",   h1_d_data, dev_d_data);
        // Message-level update on an accepted beat
        if (ev && dev_a_ready) begin
            bit done;
            if (m_left > 0) begin
                m_left--;
                done = (m_left == 0);
            end else if (beats_of(eop, esz) > 1) begin
                m_owner = g;
                m_left  = beats_of(eop, esz) - 1;
                done    = 0;
            end else begin
                done = 1;
            end
`ifndef TL_HOST_ARB_FIXED_PRIO_EN
            if (done) m_prio = 1 - g;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cyc = i;
            drive_random();
            #1;
            check_and_step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
